// File: rtl/clock_state_p.sv
// clock_state_p: shared defaults and register-file view of one clock channel's configuration.
package clock_state_p;
  localparam int CNT_W_DEF = 8;
  typedef struct packed {
    logic [CNT_W_DEF-1:0] half_period;
    logic                 active;
    logic                 set_low;
    logic                 set_high;
    logic                 pause_en;
    logic                 pause_pol;
  } chan_cfg_t;
endpackage

// File: rtl/clock_state_channel.sv
// clock_state_channel: one programmable half-period clock with set/clear override, pause and edge strobes.
module clock_state_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             sync_start,
  input  logic [CNT_W-1:0] half_period,
  input  logic             active,
  input  logic             set_low,
  input  logic             set_high,
  input  logic             pause_en,
  input  logic             pause_pol,
  output logic             state,
  output logic             pause_active,
  output logic             rise,
  output logic             fall
);
  logic [CNT_W-1:0] count, count_n, last;
  logic ls, ls_n, pa_n;
  // A half period of 0 is treated as 1, so the terminal count is 0 in both cases.
  assign last = (half_period == '0) ? '0 : half_period - 1'b1;
  always_comb begin
    count_n = count;
    ls_n = ls;
    pa_n = pause_active;
    if (sync_start) begin
      count_n = '0;
      ls_n = 1'b0;
      pa_n = 1'b0;
    end else if (set_low || set_high) begin
      count_n = '0;
      ls_n = ~set_low;
    end else if (!active) begin
      count_n = '0;
      pa_n = 1'b0;
    end else if (pause_active) begin
      pa_n = pause_en;
    end else if (pause_en && ls == pause_pol) begin
      pa_n = 1'b1;
    end else if (count >= last) begin
      count_n = '0;
      ls_n = ~ls;
    end else begin
      count_n = count + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ls <= 1'b0;
      pause_active <= 1'b0;
      state <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (clk_en) begin
      count <= count_n;
      ls <= ls_n;
      pause_active <= pa_n;
      state <= ls;
      rise <= ls & ~state;
      fall <= ~ls & state;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_clock_state.sv
// multi_clock_state: CHANNELS independent clock_state_channel instances sharing enable and sync start.
module multi_clock_state
  import clock_state_p::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      sync_start_i,
  input  logic [CHANNELS*CNT_W-1:0] half_period_i,
  input  logic [CHANNELS-1:0]       active_i,
  input  logic [CHANNELS-1:0]       set_low_i,
  input  logic [CHANNELS-1:0]       set_high_i,
  input  logic [CHANNELS-1:0]       pause_en_i,
  input  logic [CHANNELS-1:0]       pause_pol_i,
  output logic [CHANNELS-1:0]       state_o,
  output logic [CHANNELS-1:0]       pause_active_o,
  output logic [CHANNELS-1:0]       rise_o,
  output logic [CHANNELS-1:0]       fall_o
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    clock_state_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .sync_start   (sync_start_i),
      .half_period  (half_period_i[c*CNT_W +: CNT_W]),
      .active       (active_i[c]),
      .set_low      (set_low_i[c]),
      .set_high     (set_high_i[c]),
      .pause_en     (pause_en_i[c]),
      .pause_pol    (pause_pol_i[c]),
      .state        (state_o[c]),
      .pause_active (pause_active_o[c]),
      .rise         (rise_o[c]),
      .fall         (fall_o[c])
    );
  end
endmodule

// File: tb/tb_multi_clock_state.sv
// tb_multi_clock_state: random and directed stimulus checked against a behavioural channel model.
module tb_multi_clock_state;
  localparam int CH = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, clk_en, sync_start;
  logic [CH*W-1:0] hp;
  logic [CH-1:0] act, sl, sh, pe, pp;
  logic [CH-1:0] st_o, pa_o, ri_o, fa_o;
  int vectors = 0, miscompares = 0, cyc = 0;
  int m_cnt[CH];
  bit m_ls[CH], m_pa[CH], m_st[CH], m_ri[CH], m_fa[CH];
  int last_r[CH];

  multi_clock_state #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sync_start_i(sync_start),
    .half_period_i(hp), .active_i(act), .set_low_i(sl), .set_high_i(sh),
    .pause_en_i(pe), .pause_pol_i(pp), .state_o(st_o), .pause_active_o(pa_o),
    .rise_o(ri_o), .fall_o(fa_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_ls[c] = 0; m_pa[c] = 0; m_st[c] = 0; m_ri[c] = 0; m_fa[c] = 0;
    end
  endtask

  // One enabled or disabled clk edge for every channel, from the priority rules.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      int h, nc;
      bit nl, np;
      h = (hp[c*W +: W] == 0) ? 1 : int'(hp[c*W +: W]);
      if (!clk_en) begin
        m_ri[c] = 0; m_fa[c] = 0;
        continue;
      end
      nc = m_cnt[c]; nl = m_ls[c]; np = m_pa[c];
      if (sync_start) begin nc = 0; nl = 0; np = 0; end
      else if (sl[c]) begin nc = 0; nl = 0; end
      else if (sh[c]) begin nc = 0; nl = 1; end
      else if (!act[c]) begin nc = 0; np = 0; end
      else if (m_pa[c]) np = pe[c];
      else if (pe[c] && m_ls[c] == pp[c]) np = 1;
      else if (m_cnt[c] >= h - 1) begin nc = 0; nl = !m_ls[c]; end
      else nc = m_cnt[c] + 1;
      m_ri[c] = m_ls[c] && !m_st[c];
      m_fa[c] = !m_ls[c] && m_st[c];
      m_st[c] = m_ls[c];
      m_cnt[c] = nc; m_ls[c] = nl; m_pa[c] = np;
    end
  endtask

  task automatic compare();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("state[%0d]", c), 32'(st_o[c]), 32'(m_st[c]));
      check($sformatf("pause[%0d]", c), 32'(pa_o[c]), 32'(m_pa[c]));
      check($sformatf("rise[%0d]", c), 32'(ri_o[c]), 32'(m_ri[c]));
      check($sformatf("fall[%0d]", c), 32'(fa_o[c]), 32'(m_fa[c]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic track_period(input int c, input int exp);
    if (ri_o[c]) begin
      if (last_r[c] >= 0) check($sformatf("period[%0d]", c), 32'(cyc - last_r[c]), 32'(exp));
      last_r[c] = cyc;
    end
  endtask

  initial begin
    rst = 1; clk_en = 0; sync_start = 0; hp = '0; act = '0; sl = '0; sh = '0; pe = '0; pp = '0;
    model_reset();
    @(negedge clk);
    compare();
    rst = 0;
    // Free-running divide: H = 3, 1, 2, 5
    hp = {8'd5, 8'd2, 8'd1, 8'd3}; act = '1; clk_en = 1;
    for (int c = 0; c < CH; c++) last_r[c] = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      track_period(0, 6);
      track_period(1, 2);
      track_period(3, 10);
    end
    // Half-rate enable with H = 2 stretches the period to 8 clk
    sync_start = 1;
    cycle();
    sync_start = 0;
    for (int c = 0; c < CH; c++) last_r[c] = -1;
    for (int i = 0; i < 48; i++) begin
      clk_en = i[0];
      cycle();
      track_period(2, 8);
    end
    clk_en = 1;
    // Randomized operation with occasional async reset pulses
    for (int i = 0; i < 2500; i++) begin
      clk_en = ($urandom_range(9) != 0);
      sync_start = ($urandom_range(49) == 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(19) == 0) hp[c*W +: W] = 8'($urandom_range(12));
        act[c] = ($urandom_range(19) != 0);
        sl[c] = ($urandom_range(29) == 0);
        sh[c] = ($urandom_range(29) == 0);
        if ($urandom_range(7) == 0) pe[c] = ~pe[c];
        if ($urandom_range(31) == 0) pp[c] = ~pp[c];
      end
      if ($urandom_range(149) == 0) begin
        #1 rst = 1;
        #1 model_reset();
        compare();
        rst = 0;
      end
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
